// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency imem,
// holds the instruction for decode/execute and selects the next PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic        misalign_err,
    output logic [31:0] retire_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   retire_q, retire_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   next_pc;

    // Next-PC select; the jalr target has bit 0 cleared before the alignment check.
    always_comb begin
        next_pc = pc_q + XLEN'(4);
        case (PCSrc)
            2'b01:   next_pc = pc_q + ImmExt;
            2'b10:   next_pc = ALUResult & ~XLEN'(1);
            default: next_pc = pc_q + XLEN'(4);
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retire_d   = retire_q;
        err_d      = err_q;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d    = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    instr_d = NOP_INSTR;
                    if (next_pc[1:0] != 2'b00) begin
                        err_d      = 1'b1;
                        state_next = HALT;
                    end else begin
                        pc_d       = next_pc;
                        retire_d   = retire_q + XLEN'(1);
                        state_next = FETCH;
                    end
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
        req_d   = (state_next == FETCH);
        valid_d = (state_next == EXEC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            retire_q <= '0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
            err_q    <= err_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
        end
    end

    assign PC           = pc_q;
    assign PCPlus4      = pc_q + XLEN'(4);
    assign imem_addr    = pc_q;
    assign imem_req     = req_q;
    assign instr_valid  = valid_q;
    assign Instr        = instr_q;
    assign misalign_err = err_q;
    assign retire_count = retire_q;

endmodule
